// File: rtl/program_result_checker.sv
// program_result_checker: sequences one processor test (hold reset, run to end PC, settle, compare result)
// Ports: CLK/reset (sync, active-high); start/skip_reset request a test with endpc/expected latched on accept;
//        currentpc/dmemout observe the processor; proc_resetl drives the processor reset (active-low);
//        busy/done/timeout report the phase, pass the last compare; pass_count/test_count/cycle_count are statistics.
module program_result_checker #(
    parameter int unsigned    RESET_CYCLES   = 1,
    parameter int unsigned    SETTLE_CYCLES  = 1,
    parameter logic [15:0]    WATCHDOG_LIMIT = 16'h00FF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        skip_reset,
    input  logic [63:0] endpc,
    input  logic [63:0] expected,
    input  logic [63:0] currentpc,
    input  logic [63:0] dmemout,
    output logic        proc_resetl,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  pass_count,
    output logic [7:0]  test_count,
    output logic [15:0] cycle_count
);
    typedef enum logic [2:0] {IDLE, HOLD_RST, RUN, SETTLE, CHECK, DONE, TIMEOUT} state_t;
    localparam logic [7:0] RST_LAST    = 8'(RESET_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    state_t      state_q;
    logic [63:0] endpc_q, expected_q;
    logic [7:0]  wait_q, pass_count_q, test_count_q;
    logic [15:0] cycle_count_q;
    logic        pass_q;
    logic        end_hit, wd_hit, match;
    logic [7:0]  test_count_d, pass_count_d;
    logic [15:0] cycle_count_d;
    always_comb begin
        end_hit       = currentpc >= endpc_q;
        // Limit-1 here means the counter lands on the limit as RUN is left.
        wd_hit        = cycle_count_q >= WATCHDOG_LIMIT - 16'd1;
        match         = dmemout == expected_q;
        test_count_d  = (test_count_q == 8'hFF) ? test_count_q : test_count_q + 8'd1;
        pass_count_d  = (pass_count_q == 8'hFF) ? pass_count_q : pass_count_q + 8'd1;
        cycle_count_d = (cycle_count_q == 16'hFFFF) ? cycle_count_q : cycle_count_q + 16'd1;
    end
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q       <= IDLE;
            endpc_q       <= '0;
            expected_q    <= '0;
            wait_q        <= '0;
            pass_count_q  <= '0;
            test_count_q  <= '0;
            cycle_count_q <= '0;
            pass_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, TIMEOUT: begin
                    if (start) begin
                        endpc_q       <= endpc;
                        expected_q    <= expected;
                        cycle_count_q <= '0;
                        pass_q        <= 1'b0;
                        wait_q        <= '0;
                        state_q       <= skip_reset ? RUN : HOLD_RST;
                    end
                end
                HOLD_RST: begin
                    if (wait_q == RST_LAST) state_q <= RUN;
                    else wait_q <= wait_q + 8'd1;
                end
                RUN: begin
                    cycle_count_q <= cycle_count_d;
                    // End-PC detection takes priority over the watchdog.
                    if (end_hit) begin
                        wait_q  <= '0;
                        state_q <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                    end else if (wd_hit) begin
                        test_count_q <= test_count_d;
                        pass_q       <= 1'b0;
                        state_q      <= TIMEOUT;
                    end
                end
                SETTLE: begin
                    if (wait_q == SETTLE_LAST) state_q <= CHECK;
                    else wait_q <= wait_q + 8'd1;
                end
                CHECK: begin
                    pass_q       <= match;
                    test_count_q <= test_count_d;
                    if (match) pass_count_q <= pass_count_d;
                    state_q      <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign proc_resetl = state_q != HOLD_RST;
    assign busy        = (state_q == HOLD_RST) || (state_q == RUN) || (state_q == SETTLE) || (state_q == CHECK);
    assign done        = state_q == DONE;
    assign timeout     = state_q == TIMEOUT;
    assign pass        = pass_q;
    assign pass_count  = pass_count_q;
    assign test_count  = test_count_q;
    assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_program_result_checker.sv
// tb_program_result_checker: randomized and directed self-checking bench for program_result_checker
module tb_program_result_checker;
    localparam int WDL = 255;
    logic        CLK = 1'b0;
    logic        reset = 1'b1, start = 1'b0, skip_reset = 1'b0;
    logic [63:0] endpc = '0, expected = '0, dmemout = '0, currentpc;
    logic        proc_resetl, busy, done, pass, timeout;
    logic [7:0]  pass_count, test_count;
    logic [15:0] cycle_count;
    logic [63:0] pc = '0;
    logic        stuck = 1'b0;
    int          errors = 0, checks = 0, m_pass = 0, m_tests = 0;

    always #5 CLK = ~CLK;

    // Processor stand-in: PC cleared while held in reset, otherwise advances by 4.
    always @(posedge CLK) pc <= !proc_resetl ? 64'd0 : pc + 64'd4;
    assign currentpc = stuck ? 64'h10 : pc;

    program_result_checker dut (
        .CLK(CLK), .reset(reset), .start(start), .skip_reset(skip_reset),
        .endpc(endpc), .expected(expected), .currentpc(currentpc), .dmemout(dmemout),
        .proc_resetl(proc_resetl), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .pass_count(pass_count), .test_count(test_count), .cycle_count(cycle_count)
    );

    // Reference: walk the PC sequence the processor will present on each RUN cycle.
    function automatic void predict(input bit sk, input bit st, input logic [63:0] p, input logic [63:0] ep,
                                    output bit to, output int cnt);
        to = 1'b1;
        cnt = WDL;
        for (int k = 0; k < WDL; k++) begin
            logic [63:0] pk;
            pk = st ? 64'h10 : (sk ? p + 64'd4 + 64'd4 * 64'(k) : 64'd4 * 64'(k));
            if (pk >= ep) begin
                to = 1'b0;
                cnt = k + 1;
                return;
            end
        end
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic run_test(input bit sk, input logic [63:0] ep, input logic [63:0] ex, input logic [63:0] dm,
                            input bit glitch, output int rl, output int excl, output logic [63:0] p);
        int nb;
        bit fin;
        @(negedge CLK);
        skip_reset = sk; endpc = ep; expected = ex; dmemout = dm; start = 1'b1;
        p = currentpc;
        @(negedge CLK);
        rl = 0; excl = 0; nb = 0; fin = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            start = 1'b0; endpc = ep; expected = ex; skip_reset = sk;
            if (!proc_resetl) rl++;
            if (int'(busy) + int'(done) + int'(timeout) != 1) excl++;
            if (done || timeout) begin
                fin = 1'b1;
                break;
            end
            if (glitch && busy) begin
                nb++;
                if (nb == 6) begin
                    start = 1'b1; endpc = '0; expected = ~ex; skip_reset = 1'b0;
                end
            end
            @(negedge CLK);
        end
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL run_bound: no done/timeout within 2000 cycles (busy=%b)", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1;
        repeat (2) @(negedge CLK);
        m_pass = 0; m_tests = 0;
        checks++;
        if ({proc_resetl, busy, done, pass, timeout} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 10000", {proc_resetl, busy, done, pass, timeout});
        end
        checks++;
        if ({pass_count, test_count, cycle_count} !== 32'd0) begin
            errors++;
            $display("FAIL reset_counts: got %0h want 0", {pass_count, test_count, cycle_count});
        end
        reset = 1'b0; start = 1'b0;
        @(negedge CLK);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic_pass();
        int rl, excl;
        logic [63:0] p;
        stuck = 1'b0;
        run_test(1'b0, 64'h34, 64'hF, 64'hF, 1'b0, rl, excl, p);
        m_pass++; m_tests++;
        checks++;
        if (rl != 1) begin errors++; $display("FAIL basic_rst_low: got %0d want 1", rl); end
        checks++;
        if ({done, pass, timeout} !== 3'b110) begin errors++; $display("FAIL basic_flags: got %b want 110", {done, pass, timeout}); end
        checks++;
        if (pass_count !== 8'(m_pass) || test_count !== 8'(m_tests)) begin
            errors++; $display("FAIL basic_counts: got %0d/%0d want %0d/%0d", pass_count, test_count, m_pass, m_tests);
        end
        checks++;
        if (cycle_count !== 16'd14) begin errors++; $display("FAIL basic_cycles: got %0d want 14", cycle_count); end
    endtask

    task automatic test_skip_reset();
        int rl, excl, cnt;
        bit to;
        logic [63:0] p;
        run_test(1'b1, 64'h68, 64'h123456789ABCDEF0, 64'h123456789ABCDEF0, 1'b0, rl, excl, p);
        predict(1'b1, 1'b0, p, 64'h68, to, cnt);
        m_pass++; m_tests++;
        checks++;
        if (rl != 0) begin errors++; $display("FAIL skip_rst_low: got %0d want 0", rl); end
        checks++;
        if ({done, pass} !== 2'b11 || pass_count !== 8'd2 || test_count !== 8'd2) begin
            errors++; $display("FAIL skip_result: got done=%b pass=%b %0d/%0d want 1 1 2/2", done, pass, pass_count, test_count);
        end
        checks++;
        if (cycle_count !== 16'(cnt)) begin errors++; $display("FAIL skip_cycles: got %0d want %0d", cycle_count, cnt); end
    endtask

    task automatic test_fail();
        int rl, excl;
        logic [63:0] p;
        run_test(1'b0, 64'h34, 64'hF, 64'hE, 1'b0, rl, excl, p);
        m_tests++;
        repeat (3) @(negedge CLK);
        checks++;
        if ({done, pass, timeout, busy} !== 4'b1000) begin
            errors++; $display("FAIL fail_flags_held: got %b want 1000", {done, pass, timeout, busy});
        end
        checks++;
        if (pass_count !== 8'(m_pass) || test_count !== 8'(m_tests)) begin
            errors++; $display("FAIL fail_counts: got %0d/%0d want %0d/%0d", pass_count, test_count, m_pass, m_tests);
        end
    endtask

    task automatic test_timeout();
        int rl, excl;
        logic [63:0] p;
        stuck = 1'b1;
        run_test(1'b0, 64'h1000, 64'h5, 64'h5, 1'b0, rl, excl, p);
        stuck = 1'b0;
        m_tests++;
        checks++;
        if ({timeout, done, pass, busy} !== 4'b1000) begin
            errors++; $display("FAIL timeout_flags: got %b want 1000", {timeout, done, pass, busy});
        end
        checks++;
        if (cycle_count !== 16'hFF) begin errors++; $display("FAIL timeout_cycles: got %0h want ff", cycle_count); end
        checks++;
        if (pass_count !== 8'(m_pass) || test_count !== 8'(m_tests)) begin
            errors++; $display("FAIL timeout_counts: got %0d/%0d want %0d/%0d", pass_count, test_count, m_pass, m_tests);
        end
    endtask

    task automatic test_watchdog_race();
        int rl, excl;
        logic [63:0] p;
        run_test(1'b0, 64'h3F8, 64'hCAFE, 64'hCAFE, 1'b1, rl, excl, p);
        m_pass++; m_tests++;
        checks++;
        if ({done, timeout, pass} !== 3'b101) begin
            errors++; $display("FAIL race_flags: got %b want 101", {done, timeout, pass});
        end
        checks++;
        if (cycle_count !== 16'd255) begin errors++; $display("FAIL race_cycles: got %0d want 255", cycle_count); end
        checks++;
        if (excl != 0 || rl != 1) begin errors++; $display("FAIL race_phase: got excl=%0d rl=%0d want 0 1", excl, rl); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            int rl, excl, cnt;
            bit sk, to, ok;
            logic [63:0] p, ep, ex, dm;
            sk = 1'($urandom % 2);
            stuck = ($urandom % 5) == 0;
            ep = 64'($urandom_range(0, 16'h480));
            ex = {$urandom, $urandom};
            dm = ($urandom % 2) ? ex : ex ^ (64'd1 << ($urandom % 64));
            run_test(sk, ep, ex, dm, 1'b0, rl, excl, p);
            predict(sk, stuck, p, ep, to, cnt);
            ok = !to && (dm == ex);
            m_tests++;
            if (ok) m_pass++;
            checks++;
            if ({done, timeout, pass} !== {!to, to, ok}) begin
                errors++; $display("FAIL rand%0d_flags: got %b want %b", n, {done, timeout, pass}, {!to, to, ok});
            end
            checks++;
            if (cycle_count !== 16'(cnt) || rl != (sk ? 0 : 1) || excl != 0) begin
                errors++; $display("FAIL rand%0d_run: got cyc=%0d rl=%0d excl=%0d want cyc=%0d rl=%0d excl=0",
                                   n, cycle_count, rl, excl, cnt, sk ? 0 : 1);
            end
            checks++;
            if (pass_count !== 8'(sat(m_pass)) || test_count !== 8'(sat(m_tests))) begin
                errors++; $display("FAIL rand%0d_counts: got %0d/%0d want %0d/%0d", n, pass_count, test_count, m_pass, m_tests);
            end
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int rl, excl;
        logic [63:0] p;
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        run_test(1'b0, 64'h34, 64'h77, 64'h77, 1'b0, rl, excl, p);
        checks++;
        if (pass_count !== 8'd1 || test_count !== 8'd1) begin
            errors++; $display("FAIL midrun_pre: got %0d/%0d want 1/1", pass_count, test_count);
        end
        endpc = 64'hFFFF_0000; skip_reset = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (10) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        checks++;
        if ({proc_resetl, busy, done, pass, timeout, pass_count, test_count, cycle_count} !== {5'b10000, 32'd0}) begin
            errors++; $display("FAIL midrun_reset: got %b %0d/%0d/%0d want 10000 0/0/0",
                               {proc_resetl, busy, done, pass, timeout}, pass_count, test_count, cycle_count);
        end
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        checks++;
        if ({proc_resetl, busy} !== 2'b10) begin
            errors++; $display("FAIL midhold_reset: got resetl=%b busy=%b want 1 0", proc_resetl, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_skip_reset();
        test_fail();
        test_timeout();
        test_watchdog_race();
        test_random();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/program_result_checker.md
PROGRAM_RESULT_CHECKER -- requirements
Module: program_result_checker

Interface
REQ-001 Parameter RESET_CYCLES, default 1: number of cycles proc_resetl SHALL be held low per test (range 1-255).
REQ-002 Parameter SETTLE_CYCLES, default 1: wait cycles between end-PC detection and the result compare (range 0-255).
REQ-003 Parameter WATCHDOG_LIMIT, default 16'h00FF: maximum RUN cycles per test before timeout.
REQ-004 CLK  in  1  the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a test; sampled only in IDLE, DONE and TIMEOUT.
REQ-007 skip_reset  in  1  sampled with start; 1 means continue the running program without pulsing proc_resetl.
REQ-008 endpc  in  64  end-of-program PC; latched on accepted start.
REQ-009 expected  in  64  expected data-memory result; latched on accepted start.
REQ-010 currentpc  in  64  processor current PC.
REQ-011 dmemout  in  64  processor data-memory read output.
REQ-012 proc_resetl  out  1  active-low reset to the processor.
REQ-013 busy  out  1  high in HOLD_RST, RUN, SETTLE and CHECK.
REQ-014 done  out  1  high in DONE.
REQ-015 pass  out  1  result of the last completed compare; valid while done=1.
REQ-016 timeout  out  1  high in TIMEOUT.
REQ-017 pass_count  out  8  number of tests passed since reset.
REQ-018 test_count  out  8  number of tests finished (pass, fail or timeout) since reset.
REQ-019 cycle_count  out  16  RUN cycles elapsed in the current or last test.

Function
REQ-020 The FSM SHALL have the states IDLE, HOLD_RST, RUN, SETTLE, CHECK, DONE and TIMEOUT.
REQ-021 In IDLE, DONE or TIMEOUT, start=1 SHALL latch endpc and expected, clear cycle_count and pass, and go to HOLD_RST (skip_reset=0) or RUN (skip_reset=1).
REQ-022 While busy=1, start SHALL be ignored and the latched operands SHALL NOT change.
REQ-023 proc_resetl SHALL be 0 in HOLD_RST and 1 in all other states, decoded from the state register with no extra latency.
REQ-024 HOLD_RST SHALL last exactly RESET_CYCLES cycles, then go to RUN.
REQ-025 In RUN, cycle_count SHALL increment every cycle and saturate at 16'hFFFF.
REQ-026 In RUN, currentpc >= latched endpc (unsigned 64-bit) SHALL go to SETTLE, or directly to CHECK if SETTLE_CYCLES=0.
REQ-027 In RUN, if the end-PC condition is false and cycle_count reaches WATCHDOG_LIMIT-1 this cycle, the FSM SHALL go to TIMEOUT.
REQ-028 If the end-PC and watchdog conditions are true in the same cycle, end-PC detection SHALL win.
REQ-029 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-030 CHECK SHALL last one cycle and compare dmemout with the latched expected over all 64 bits.
REQ-031 In CHECK, pass SHALL be registered as the compare result and test_count SHALL increment.
REQ-032 In CHECK, pass_count SHALL increment on a match; the FSM then goes to DONE.
REQ-033 On entry to TIMEOUT, test_count SHALL increment, pass SHALL be 0 and pass_count SHALL NOT change.
REQ-034 pass_count and test_count SHALL saturate at 8'hFF.
REQ-035 DONE and TIMEOUT SHALL be held until an accepted start or reset.
REQ-036 Exactly one of done, timeout or busy SHALL be high outside IDLE; all three SHALL be low in IDLE.

Reset
REQ-037 With reset=1 at a clock edge, the FSM SHALL go to IDLE and all counters, pass and the latched operands SHALL clear to 0.
REQ-038 After reset: proc_resetl=1; busy, done, pass and timeout = 0; pass_count, test_count and cycle_count = 0.
REQ-039 Reset SHALL take priority over start and over any in-progress test, including mid-RUN and mid-HOLD_RST.

Verification
REQ-040 start, skip_reset=0, endpc=0x34, expected=0xF; PC advances 4 per cycle from 0; dmemout=0xF at CHECK -> proc_resetl low 1 cycle, done=1, pass=1, pass_count=1, test_count=1, cycle_count=14.
REQ-041 Following REQ-040: start, skip_reset=1, endpc=0x68, expected=0x123456789ABCDEF0, matching dmemout -> proc_resetl never low, pass=1, pass_count=2, test_count=2.
REQ-042 endpc=0x34, expected=0xF, dmemout=0xE at CHECK -> done=1, pass=0, pass_count unchanged, test_count incremented.
REQ-043 currentpc stuck at 0x10, WATCHDOG_LIMIT=0xFF -> timeout=1 after exactly 255 RUN cycles, cycle_count=0xFF, done=0, test_count incremented.
REQ-044 currentpc reaches endpc on cycle WATCHDOG_LIMIT-1 -> SETTLE is entered, not TIMEOUT; start pulsed during RUN is ignored.
REQ-045 reset asserted mid-RUN with counts at 1/1 -> next cycle IDLE, all outputs at the values of REQ-038.
